// File: rtl/seg7_scan_mux.sv
// ============================================================================
// Module      : seg7_scan_mux
// Description : Time-multiplexed common-anode 7-segment driver with per-frame
//               shadow of digit nibbles. Optional LEADING_ZERO_BLANK_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg7,
  output logic                          dp,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
  output logic                          frame_tick
);

  localparam int c_sel_w = $clog2(NUM_DIGITS);
  localparam int c_pre_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [c_pre_w-1:0]      r_pre;
  logic [c_sel_w-1:0]      r_index;
  logic [4*NUM_DIGITS-1:0] r_shadow_digits;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;

  logic                    w_tc;
  logic                    w_last;
  logic [3:0]              w_nib;
  logic                    w_sel_dp;
  logic                    w_sel_blank;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [NUM_DIGITS-1:0]   w_blank;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    f_decode = 7'b0000001;
      4'h1:    f_decode = 7'b1001111;
      4'h2:    f_decode = 7'b0010010;
      4'h3:    f_decode = 7'b0000110;
      4'h4:    f_decode = 7'b1001100;
      4'h5:    f_decode = 7'b0100100;
      4'h6:    f_decode = 7'b0100000;
      4'h7:    f_decode = 7'b0001111;
      4'h8:    f_decode = 7'b0000000;
      4'h9:    f_decode = 7'b0000100;
      4'hA:    f_decode = 7'b0001000;
      4'hB:    f_decode = 7'b1100000;
      4'hC:    f_decode = 7'b0110001;
      4'hD:    f_decode = 7'b1000010;
      4'hE:    f_decode = 7'b0110000;
      default: f_decode = 7'b0111000;
    endcase
  endfunction

  assign w_tc     = (r_pre == c_pre_w'(REFRESH_DIV - 1));
  assign w_last   = (r_index == c_sel_w'(NUM_DIGITS - 1));
  assign w_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_index;

`ifdef LEADING_ZERO_BLANK_EN
  // w_zero_above[i]: shadow nibbles i..NUM_DIGITS-1 are all zero
  logic [NUM_DIGITS-1:1] w_zero_above;
  assign w_blank[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
    if (gi == NUM_DIGITS - 1) begin : g_top
      assign w_zero_above[gi] = (r_shadow_digits[4*gi +: 4] == 4'h0);
    end else begin : g_mid
      assign w_zero_above[gi] = (r_shadow_digits[4*gi +: 4] == 4'h0) && w_zero_above[gi+1];
    end
    assign w_blank[gi] = w_zero_above[gi] && !r_shadow_dp[gi];
  end
`else
  assign w_blank = '0;
`endif

  always_comb begin
    w_nib       = 4'h0;
    w_sel_dp    = 1'b0;
    w_sel_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_index == c_sel_w'(i)) begin
        w_nib       = r_shadow_digits[4*i +: 4];
        w_sel_dp    = r_shadow_dp[i];
        w_sel_blank = w_blank[i];
      end
    end
  end

  // Outputs are registered from the pre-update index, giving one cycle of latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre           <= '0;
      r_index         <= '0;
      r_shadow_digits <= '0;
      r_shadow_dp     <= '0;
      an              <= '1;
      seg7            <= 7'b1111111;
      dp              <= 1'b1;
      digit_sel       <= '0;
      frame_tick      <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      digit_sel  <= r_index;
      if (enable) begin
        if (w_tc) begin
          r_pre <= '0;
          if (w_last) begin
            r_index         <= '0;
            r_shadow_digits <= digits;
            r_shadow_dp     <= dp_mask;
            frame_tick      <= 1'b1;
          end else begin
            r_index <= r_index + 1'b1;
          end
        end else begin
          r_pre <= r_pre + 1'b1;
        end
        an   <= w_sel_blank ? '1 : ~w_onehot;
        seg7 <= w_sel_blank ? 7'b1111111 : f_decode(w_nib);
        dp   <= w_sel_blank ? 1'b1 : ~w_sel_dp;
      end else begin
        an   <= '1;
        seg7 <= 7'b1111111;
        dp   <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
